// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_RUN   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Divide ops have op[1] set; signed ops have op[0] clear.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Multiply: {acc,q} holds {partial product, remaining multiplier bits}; shifts right.
// Divide:   {acc,q} holds {partial remainder, dividend/quotient bits}; shifts left.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] opnd,
    input  logic             is_div,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] diff;

    // Single combinational step; the shifted remainder needs one extra bit for the compare.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, opnd};
        rem      = {acc, q[WIDTH-1]};
        diff     = rem[WIDTH-1:0] - opnd;
        acc_next = acc;
        q_next   = q;
        if (is_div) begin
            if (rem >= {1'b0, opnd}) begin
                acc_next = diff;
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else if (q[0]) begin
            {acc_next, q_next} = {sum, q[WIDTH-1:1]};
        end else begin
            {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the shared iterative mul/div unit and owns HI/LO.
// Handshake: an op is accepted on a rising edge where start=1, flush=0 and the unit is
// in IDLE or DONE (stall=0); while busy, start is held and stall stays high.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output state_e           dbg_state
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q_q, neg_q_d;     // product / quotient is negative
    logic               neg_rem_q, neg_rem_d; // remainder is negative
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   step_acc, step_q;
    logic [2*WIDTH-1:0] prod;
    logic               is_div, is_signed;

    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .q        (q_q),
        .opnd     (opnd_q),
        .is_div   (is_div),
        .acc_next (step_acc),
        .q_next   (step_q)
    );

    assign busy      = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIXUP);
    assign stall     = busy & (start | mf_req);
    assign done      = (state_q == S_DONE);
    assign div_zero  = done & dz_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign dbg_state = state_q;

    // Next-state, datapath loading and HI/LO commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        q_d       = q_q;
        opnd_d    = opnd_q;
        neg_q_d   = neg_q_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod      = {acc_q, q_q};
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !flush) begin
                    state_d = S_PREP;
                    op_d    = op;
                    // q carries the dividend or the multiplier; opnd the divisor or multiplicand.
                    q_d     = op_is_div(op) ? rs_val : rt_val;
                    opnd_d  = op_is_div(op) ? rt_val : rs_val;
                end
            end
            S_PREP: begin
                neg_q_d   = is_signed & (q_q[WIDTH-1] ^ opnd_q[WIDTH-1]);
                neg_rem_d = is_signed & is_div & q_q[WIDTH-1];
                q_d       = (is_signed && q_q[WIDTH-1]) ? -q_q : q_q;
                opnd_d    = (is_signed && opnd_q[WIDTH-1]) ? -opnd_q : opnd_q;
                dz_d      = is_div & (opnd_q == '0);
                acc_d     = '0;
                cnt_d     = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_DONE;
                if (!dz_q) begin
                    if (is_div) begin
                        lo_d = neg_q_q ? -q_q : q_q;
                        hi_d = neg_rem_q ? -acc_q : acc_q;
                    end else begin
                        prod = neg_q_q ? ((2 * WIDTH)'(0) - {acc_q, q_q}) : {acc_q, q_q};
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Squash wins over any in-flight work, including the FIXUP commit.
        if (flush && busy) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            opnd_q    <= '0;
            neg_q_q   <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            opnd_q    <= opnd_d;
            neg_q_q   <= neg_q_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
